// File: rtl/joy_db9_arcade_map.sv
// DB9 joystick post-processing: per-bit debounce on a ms tick, held-combo coin/start pulses.
// Define JOY_AUTOFIRE_EN to add Fire2-driven autofire on the Fire1 output bit.

module joy_db9_player #(
  parameter int DEB_TICKS   = 4,
  parameter int HOLD_TICKS  = 1000,
  parameter int PULSE_TICKS = 100,
  parameter int AF_PERIOD   = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [5:0] raw,
  output logic [5:0] joy_out,
  output logic       coin,
  output logic       start
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int PW = $clog2(PULSE_TICKS + 1);

  if (DEB_TICKS < 1 || HOLD_TICKS < 1 || PULSE_TICKS < 1 || AF_PERIOD < 1) begin : g_bad_param
    $error("joy_db9_player: tick counts must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRE, S_WAIT} state_t;

  logic [5:0]         deb, deb_nxt;
  logic [5:0][DW-1:0] dcnt, dcnt_nxt;
  state_t             state, state_nxt;
  logic               kind, kind_nxt;   // 0 = coin, 1 = start
  logic [HW-1:0]      hold, hold_nxt;
  logic [PW-1:0]      pulse, pulse_nxt;
  logic               f1, fire, mask;
  logic               coin_m, start_m;

  always_comb begin
    deb_nxt  = deb;
    dcnt_nxt = dcnt;
    if (tick) begin
      for (int i = 0; i < 6; i++) begin
        if (raw[i] != deb[i]) begin
          if (dcnt[i] == DW'(DEB_TICKS - 1)) begin
            deb_nxt[i]  = raw[i];
            dcnt_nxt[i] = '0;
          end else begin
            dcnt_nxt[i] = dcnt[i] + DW'(1);
          end
        end else begin
          dcnt_nxt[i] = '0;
        end
      end
    end
  end

  // Combos are judged on the debounced state as it stood before this tick.
  assign coin_m  = deb[4] & deb[5] & deb[3];
  assign start_m = deb[4] & deb[5] & deb[2] & ~deb[3];

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    hold_nxt  = hold;
    pulse_nxt = pulse;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (coin_m) begin
            state_nxt = S_ARMED;
            kind_nxt  = 1'b0;
            hold_nxt  = HW'(1);
          end else if (start_m) begin
            state_nxt = S_ARMED;
            kind_nxt  = 1'b1;
            hold_nxt  = HW'(1);
          end
        end
        S_ARMED: begin
          if (kind ? start_m : coin_m) begin
            hold_nxt = (hold < HW'(HOLD_TICKS)) ? hold + HW'(1) : hold;
            if (hold >= HW'(HOLD_TICKS - 1)) begin
              state_nxt = S_FIRE;
              pulse_nxt = '0;
            end
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_FIRE: begin
          pulse_nxt = (pulse < PW'(PULSE_TICKS)) ? pulse + PW'(1) : pulse;
          if (pulse >= PW'(PULSE_TICKS - 1)) state_nxt = S_WAIT;
        end
        default: begin
          if (!deb[4] && !deb[5]) state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign fire = (state_nxt == S_FIRE);
  assign mask = (state_nxt == S_FIRE) || (state_nxt == S_WAIT);

`ifdef JOY_AUTOFIRE_EN
  localparam int AW = $clog2(AF_PERIOD + 1);
  logic          af_on, af_on_nxt, af_ph, af_ph_nxt;
  logic [AW-1:0] af_cnt, af_cnt_nxt;

  always_comb begin
    af_on_nxt  = af_on;
    af_ph_nxt  = af_ph;
    af_cnt_nxt = af_cnt;
    if (tick) begin
      af_on_nxt = deb_nxt[5] && (state_nxt == S_IDLE);
      if (af_on_nxt) begin
        if (!af_on) begin
          af_ph_nxt  = 1'b1;
          af_cnt_nxt = AW'(1);
        end else if (af_cnt >= AW'(AF_PERIOD)) begin
          af_ph_nxt  = ~af_ph;
          af_cnt_nxt = AW'(1);
        end else begin
          af_cnt_nxt = af_cnt + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      af_on  <= 1'b0;
      af_ph  <= 1'b0;
      af_cnt <= '0;
    end else begin
      af_on  <= af_on_nxt;
      af_ph  <= af_ph_nxt;
      af_cnt <= af_cnt_nxt;
    end
  end

  assign f1 = deb_nxt[4] | (af_on_nxt & af_ph_nxt);
`else
  assign f1 = deb_nxt[4];
`endif

  // Outputs are registered from next-state so they land the cycle after the tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb     <= '0;
      dcnt    <= '0;
      state   <= S_IDLE;
      kind    <= 1'b0;
      hold    <= '0;
      pulse   <= '0;
      joy_out <= '0;
      coin    <= 1'b0;
      start   <= 1'b0;
    end else begin
      deb     <= deb_nxt;
      dcnt    <= dcnt_nxt;
      state   <= state_nxt;
      kind    <= kind_nxt;
      hold    <= hold_nxt;
      pulse   <= pulse_nxt;
      joy_out <= {mask ? 1'b0 : deb_nxt[5], mask ? 1'b0 : f1, deb_nxt[3:0]};
      coin    <= fire & ~kind_nxt;
      start   <= fire & kind_nxt;
    end
  end

endmodule

module joy_db9_arcade_map #(
  parameter int CLK_DIV     = 48000,
  parameter int DEB_TICKS   = 4,
  parameter int HOLD_TICKS  = 1000,
  parameter int PULSE_TICKS = 100,
  parameter int AF_PERIOD   = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  output logic [5:0]  joy1_out,
  output logic [5:0]  joy2_out,
  output logic [1:0]  coin,
  output logic [1:0]  start,
  output logic        tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 2) begin : g_bad_div
    $error("joy_db9_arcade_map: CLK_DIV must be >= 2");
  end

  logic [CW-1:0]      div;
  logic [1:0][5:0]    raw;
  logic [1:0][5:0]    jo;
  logic               unused_hi;

  assign unused_hi = ^{joystick1[15:6], joystick2[15:6]};
  assign tick      = (div == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      raw <= '0;
    end else begin
      div <= tick ? '0 : div + CW'(1);
      raw <= {joystick2[5:0], joystick1[5:0]};
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_pl
    joy_db9_player #(
      .DEB_TICKS  (DEB_TICKS),
      .HOLD_TICKS (HOLD_TICKS),
      .PULSE_TICKS(PULSE_TICKS),
      .AF_PERIOD  (AF_PERIOD)
    ) u_pl (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .raw    (raw[p]),
      .joy_out(jo[p]),
      .coin   (coin[p]),
      .start  (start[p])
    );
  end

  assign joy1_out = jo[0];
  assign joy2_out = jo[1];

endmodule

// File: tb/tb_joy_db9_arcade_map.sv
// Directed bench for joy_db9_arcade_map with short tick/debounce/hold constants.
module tb_joy_db9_arcade_map;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] joystick1 = '0, joystick2 = '0;
  logic [5:0]  joy1_out, joy2_out;
  logic [1:0]  coin, start;
  logic        tick;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  joy_db9_arcade_map #(
    .CLK_DIV(4), .DEB_TICKS(2), .HOLD_TICKS(3), .PULSE_TICKS(2), .AF_PERIOD(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .joystick1(joystick1), .joystick2(joystick2),
    .joy1_out(joy1_out), .joy2_out(joy2_out), .coin(coin), .start(start), .tick(tick)
  );

  typedef struct {
    logic [15:0] j1, j2;
    int          nt;
    logic [5:0]  e1, e2;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Ends at the negedge one cycle after the n-th tick strobe.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int b = 0;
      do begin
        @(negedge clk);
        b++;
      end while (!tick && b < 20);
      if (!tick) begin
        nvec++;
        nerr++;
        $display("FAIL tick_timeout: got no tick within %0d cycles want tick", b);
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_all(input string nm, input logic [5:0] e1, input logic [5:0] e2,
                         input logic [1:0] ec, input logic [1:0] es);
    chk({nm, ".joy1"}, 16'(joy1_out), 16'(e1));
    chk({nm, ".joy2"}, 16'(joy2_out), 16'(e2));
    chk({nm, ".coin"}, 16'(coin), 16'(ec));
    chk({nm, ".start"}, 16'(start), 16'(es));
  endtask

  initial begin
    int n;
    logic [5:0] af_exp[9];

    vt[0]  = '{16'h0001, 16'h0000, 1, 6'h00, 6'h00};
    vt[1]  = '{16'h0001, 16'h0000, 1, 6'h01, 6'h00};
    vt[2]  = '{16'h0000, 16'h0000, 1, 6'h01, 6'h00};
    vt[3]  = '{16'h0001, 16'h0000, 1, 6'h01, 6'h00};
    vt[4]  = '{16'h0000, 16'h0000, 1, 6'h01, 6'h00};
    vt[5]  = '{16'h0000, 16'h0000, 1, 6'h00, 6'h00};
    vt[6]  = '{16'h0001, 16'h0000, 1, 6'h00, 6'h00};
    vt[7]  = '{16'h0000, 16'h0000, 1, 6'h00, 6'h00};
    vt[8]  = '{16'h0000, 16'h0000, 2, 6'h00, 6'h00};
    vt[9]  = '{16'hFFC2, 16'hAA0C, 2, 6'h02, 6'h0C};
    vt[10] = '{16'h0010, 16'h0003, 2, 6'h10, 6'h03};
    vt[11] = '{16'h0000, 16'h0000, 2, 6'h00, 6'h00};

    // Reset: high-order garbage on the inputs must not leak.
    joystick1 = 16'hFFFF;
    joystick2 = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk_all("reset", 6'h00, 6'h00, 2'b00, 2'b00);
    chk("reset.tick", 16'(tick), 16'h0);
    joystick1 = '0;
    joystick2 = '0;
    rst_n = 1'b1;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 10);
    chk("first_tick", 16'(n), 16'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 10);
    chk("tick_period", 16'(n), 16'd4);

    // Debounce vectors, including a one-tick glitch and ignored upper bits.
    for (int i = 0; i < 12; i++) begin
      joystick1 = vt[i].j1;
      joystick2 = vt[i].j2;
      wait_ticks(vt[i].nt);
      chk_all($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, 2'b00, 2'b00);
    end

    // Coin combo: 2 debounce ticks + 3 hold ticks, then an 8-cycle pulse.
    joystick1 = 16'h0038;
    wait_ticks(2);
    chk_all("coin_deb", 6'h38, 6'h00, 2'b00, 2'b00);
    wait_ticks(2);
    chk_all("coin_hold", 6'h38, 6'h00, 2'b00, 2'b00);
    wait_ticks(1);
    chk_all("coin_fire", 6'h08, 6'h00, 2'b01, 2'b00);
    n = 0;
    while (coin[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("coin_width", 16'(n), 16'd8);
    wait_ticks(2);
    chk_all("coin_waitrel", 6'h08, 6'h00, 2'b00, 2'b00);
    joystick1 = 16'h0000;
    wait_ticks(2);
    chk_all("coin_release", 6'h00, 6'h00, 2'b00, 2'b00);
    joystick1 = 16'h0030;
    wait_ticks(2);
    chk_all("back_idle", 6'h30, 6'h00, 2'b00, 2'b00);
    joystick1 = 16'h0000;
    wait_ticks(2);

    // Both players at once; U+D with F1F2 counts as coin.
    joystick1 = 16'h003C;
    joystick2 = 16'h0034;
    wait_ticks(4);
    chk_all("dual_hold", 6'h3C, 6'h34, 2'b00, 2'b00);
    wait_ticks(1);
    chk_all("dual_fire", 6'h0C, 6'h04, 2'b01, 2'b10);
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    wait_ticks(3);
    chk_all("dual_done", 6'h00, 6'h00, 2'b00, 2'b00);

    // Combo broken while armed: no pulse.
    joystick1 = 16'h0038;
    wait_ticks(2);
    joystick1 = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      wait_ticks(1);
      chk("abort.coin", 16'(coin), 16'h0);
    end
    chk("abort.joy1", 16'(joy1_out), 16'h0);

    // Re-arm from IDLE, then reset during FIRE.
    joystick1 = 16'h0038;
    wait_ticks(4);
    chk("rearm.coin_early", 16'(coin), 16'h0);
    wait_ticks(1);
    chk("rearm.coin", 16'(coin), 16'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_fire.coin", 16'(coin), 16'h0);
    chk("rst_fire.joy1", 16'(joy1_out), 16'h0);
    joystick1 = 16'h0020;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fire2 alone: autofire pattern on bit4 when enabled, plain otherwise.
`ifdef JOY_AUTOFIRE_EN
    af_exp = '{6'h00, 6'h30, 6'h30, 6'h20, 6'h20, 6'h30, 6'h30, 6'h20, 6'h00};
`else
    af_exp = '{6'h00, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h00};
`endif
    for (int i = 0; i < 9; i++) begin
      if (i == 7) joystick1 = 16'h0000;
      wait_ticks(1);
      chk($sformatf("fire2_t%0d", i + 1), 16'(joy1_out), 16'(af_exp[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
